// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state type and amount limits for the keypad capture block.
package keypad_pkg;

   localparam logic [3:0]  KEY_ENTER  = 4'hA;
   localparam logic [3:0]  KEY_CLEAR  = 4'hB;
   localparam logic [35:0] MAX_AMOUNT = 36'h0_FFFF_FFFF;

   typedef enum logic [1:0] {
      StIdle,
      StDebounce,
      StHold
   } key_state_e;

   // Widened so an overflow past 32 bits is still visible to the caller.
   function automatic logic [35:0] acc_mul10_add(input logic [31:0] acc, input logic [3:0] d);
      return ({4'b0000, acc} * 36'd10) + {32'd0, d};
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Key debounce FSM: one accept pulse per press. KEYPAD_DEBOUNCE_EN enables the
// stable-cycle filter; without it a key is accepted on its first sampled cycle.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DebCycles = 3
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       key_valid_i,
   input  logic [3:0] key_i,
   output logic       accept_o,
   output logic [3:0] code_o
);

`ifdef KEYPAD_DEBOUNCE_EN
   localparam bit DebounceEn = 1'b1;
`else
   localparam bit DebounceEn = 1'b0;
`endif
   localparam logic [3:0] DebLast = 4'(DebCycles);

   key_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] code_q, code_d;
   logic       accept_q, accept_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      code_d   = code_q;
      accept_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (key_valid_i) begin
               code_d = key_i;
               if (DebounceEn) begin
                  state_d = StDebounce;
                  cnt_d   = 4'd1;
               end else begin
                  state_d  = StHold;
                  accept_d = 1'b1;
               end
            end
         end
         StDebounce: begin
            if (!key_valid_i || (key_i != code_q)) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
            end else if (cnt_q >= DebLast) begin
               state_d  = StHold;
               cnt_d    = 4'd0;
               accept_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StHold: begin
            if (!key_valid_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         code_q   <= 4'd0;
         accept_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         code_q   <= code_d;
         accept_q <= accept_d;
      end
   end

   assign accept_o = accept_q;
   assign code_o   = code_q;

endmodule

// File: rtl/keypad_capture.sv
// Keypad capture top: PIN digit strobes and decimal amount accumulation.
// Debounce filtering is enabled by defining KEYPAD_DEBOUNCE_EN.
module keypad_capture
   import keypad_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        TECLA_VALIDA,
   input  logic [3:0]  TECLA,
   input  logic        MODO_MONTO,
   output logic [3:0]  DIGITO,
   output logic        DIGITO_STB,
   output logic [31:0] MONTO,
   output logic        MONTO_STB,
   output logic        DESBORDE
);

   logic        accept;
   logic [3:0]  code;

   logic [3:0]  digito_q, digito_d;
   logic        digito_stb_q, digito_stb_d;
   logic [31:0] monto_q, monto_d;
   logic        monto_stb_q, monto_stb_d;
   logic        desborde_q, desborde_d;
   logic [31:0] acc_q, acc_d;
   logic [3:0]  count_q, count_d;
   logic        modo_q;

   logic [31:0] acc_base;
   logic [3:0]  count_base;
   logic [35:0] acc_ext;

   keypad_debounce #(
      .DebCycles (DEB_CYCLES)
   ) u_debounce (
      .clk_i       (CLK),
      .rst_ni      (RESET),
      .key_valid_i (TECLA_VALIDA),
      .key_i       (TECLA),
      .accept_o    (accept),
      .code_o      (code)
   );

   always_comb begin
      // A mode change wipes any partial amount before this cycle's key is applied.
      acc_base   = (MODO_MONTO != modo_q) ? 32'd0 : acc_q;
      count_base = (MODO_MONTO != modo_q) ? 4'd0 : count_q;
      acc_ext    = acc_mul10_add(acc_base, code);

      digito_d     = digito_q;
      digito_stb_d = 1'b0;
      monto_d      = monto_q;
      monto_stb_d  = 1'b0;
      desborde_d   = 1'b0;
      acc_d        = acc_base;
      count_d      = count_base;

      if (accept) begin
         if (code <= 4'd9) begin
            if (!MODO_MONTO) begin
               digito_d     = code;
               digito_stb_d = 1'b1;
            end else if (acc_ext > MAX_AMOUNT) begin
               desborde_d = 1'b1;
            end else begin
               acc_d   = acc_ext[31:0];
               count_d = (count_base == 4'hF) ? count_base : count_base + 4'd1;
            end
         end else if (code == KEY_ENTER) begin
            if (MODO_MONTO && (count_base != 4'd0)) begin
               monto_d     = acc_base;
               monto_stb_d = 1'b1;
               acc_d       = 32'd0;
               count_d     = 4'd0;
            end
         end else if (code == KEY_CLEAR) begin
            if (MODO_MONTO) begin
               acc_d   = 32'd0;
               count_d = 4'd0;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         digito_q     <= 4'd0;
         digito_stb_q <= 1'b0;
         monto_q      <= 32'd0;
         monto_stb_q  <= 1'b0;
         desborde_q   <= 1'b0;
         acc_q        <= 32'd0;
         count_q      <= 4'd0;
         modo_q       <= MODO_MONTO;
      end else begin
         digito_q     <= digito_d;
         digito_stb_q <= digito_stb_d;
         monto_q      <= monto_d;
         monto_stb_q  <= monto_stb_d;
         desborde_q   <= desborde_d;
         acc_q        <= acc_d;
         count_q      <= count_d;
         modo_q       <= MODO_MONTO;
      end
   end

   assign DIGITO     = digito_q;
   assign DIGITO_STB = digito_stb_q;
   assign MONTO      = monto_q;
   assign MONTO_STB  = monto_stb_q;
   assign DESBORDE   = desborde_q;

endmodule

// File: tb/tb_keypad_capture.sv
// Directed self-checking bench for keypad_capture (PIN, amount, overflow, glitch, reset).
module tb_keypad_capture;

   localparam int unsigned Deb = 3;
`ifdef KEYPAD_DEBOUNCE_EN
   localparam int Lat = Deb + 1;
   localparam int GlitchDigits = 1;
`else
   localparam int Lat = 1;
   localparam int GlitchDigits = 2;
`endif

   logic        CLK;
   logic        RESET;
   logic        TECLA_VALIDA;
   logic [3:0]  TECLA;
   logic        MODO_MONTO;
   logic [3:0]  DIGITO;
   logic        DIGITO_STB;
   logic [31:0] MONTO;
   logic        MONTO_STB;
   logic        DESBORDE;

   keypad_capture #(
      .DEB_CYCLES (Deb)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .TECLA_VALIDA (TECLA_VALIDA),
      .TECLA        (TECLA),
      .MODO_MONTO   (MODO_MONTO),
      .DIGITO       (DIGITO),
      .DIGITO_STB   (DIGITO_STB),
      .MONTO        (MONTO),
      .MONTO_STB    (MONTO_STB),
      .DESBORDE     (DESBORDE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          press_start = 0;
   int          n_dstb, n_mstb, n_ovf, n_both;
   int          last_lat;
   logic [3:0]  last_dig;

   int pin_keys [4] = '{3, 4, 7, 3};
   int big_keys [10] = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 5};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_counts();
      n_dstb   = 0;
      n_mstb   = 0;
      n_ovf    = 0;
      last_lat = -1;
      last_dig = 4'hF;
   endtask

   // Advance one clock and log any strobes seen just after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
      if (DIGITO_STB) begin
         n_dstb++;
         last_dig = DIGITO;
         last_lat = cyc - press_start;
      end
      if (MONTO_STB) n_mstb++;
      if (DESBORDE) n_ovf++;
      if (DIGITO_STB && MONTO_STB) n_both++;
   endtask

   task automatic press(input logic [3:0] k, input int hold);
      TECLA        = k;
      TECLA_VALIDA = 1'b1;
      press_start  = cyc + 1;
      repeat (hold) step();
      TECLA_VALIDA = 1'b0;
      repeat (3) step();
   endtask

   task automatic set_mode(input logic m);
      MODO_MONTO = m;
      repeat (2) step();
   endtask

   initial begin
      n_both       = 0;
      clr_counts();
      RESET        = 1'b0;
      TECLA_VALIDA = 1'b0;
      TECLA        = 4'd0;
      MODO_MONTO   = 1'b0;
      repeat (2) step();
      check_eq("rst_digito", 32'(DIGITO), 32'd0);
      check_eq("rst_digito_stb", 32'(DIGITO_STB), 32'd0);
      check_eq("rst_monto", MONTO, 32'd0);
      check_eq("rst_monto_stb", 32'(MONTO_STB), 32'd0);
      check_eq("rst_desborde", 32'(DESBORDE), 32'd0);
      RESET = 1'b1;
      repeat (2) step();

      // PIN digits with latency check
      clr_counts();
      for (int i = 0; i < 4; i++) begin
         press(4'(pin_keys[i]), 5);
         check_eq($sformatf("pin_digit%0d", i), 32'(last_dig), 32'(pin_keys[i]));
         check_eq($sformatf("pin_latency%0d", i), 32'(last_lat), 32'(Lat));
      end
      check_eq("pin_strobe_count", 32'(n_dstb), 32'd4);

      // Amount 2000
      set_mode(1'b1);
      clr_counts();
      press(4'd2, 5);
      press(4'd0, 5);
      press(4'd0, 5);
      press(4'd0, 5);
      check_eq("amt_no_early_commit", 32'(n_mstb), 32'd0);
      press(4'hA, 5);
      check_eq("amt_commit_count", 32'(n_mstb), 32'd1);
      check_eq("amt_2000", MONTO, 32'h7D0);
      check_eq("amt_no_digit_stb", 32'(n_dstb), 32'd0);

      // Glitch then held 5, PIN mode
      set_mode(1'b0);
      clr_counts();
      TECLA        = 4'd6;
      TECLA_VALIDA = 1'b1;
      repeat (2) step();
      TECLA_VALIDA = 1'b0;
      repeat (2) step();
      press(4'd5, 10);
      check_eq("glitch_digit_count", 32'(n_dstb), 32'(GlitchDigits));
      check_eq("glitch_last_digit", 32'(last_dig), 32'd5);

      // Overflow at max amount
      set_mode(1'b1);
      clr_counts();
      for (int i = 0; i < 10; i++) press(4'(big_keys[i]), 5);
      check_eq("max_no_overflow", 32'(n_ovf), 32'd0);
      press(4'd1, 5);
      check_eq("overflow_pulse", 32'(n_ovf), 32'd1);
      press(4'hA, 5);
      check_eq("max_commit_count", 32'(n_mstb), 32'd1);
      check_eq("max_monto", MONTO, 32'hFFFF_FFFF);

      // CLEAR, then ENTER with nothing entered
      clr_counts();
      press(4'd9, 5);
      press(4'd9, 5);
      press(4'hB, 5);
      press(4'd1, 5);
      press(4'hA, 5);
      check_eq("clear_monto", MONTO, 32'd1);
      check_eq("clear_commit_count", 32'(n_mstb), 32'd1);
      clr_counts();
      press(4'hA, 5);
      check_eq("empty_enter_no_stb", 32'(n_mstb), 32'd0);
      check_eq("empty_enter_hold", MONTO, 32'd1);

      // Reset mid-entry while a key is held
      clr_counts();
      press(4'd1, 5);
      press(4'd2, 5);
      TECLA        = 4'd3;
      TECLA_VALIDA = 1'b1;
      repeat (2) step();
      RESET = 1'b0;
      step();
      check_eq("midrst_digito", 32'(DIGITO), 32'd0);
      check_eq("midrst_digito_stb", 32'(DIGITO_STB), 32'd0);
      check_eq("midrst_monto", MONTO, 32'd0);
      check_eq("midrst_monto_stb", 32'(MONTO_STB), 32'd0);
      check_eq("midrst_desborde", 32'(DESBORDE), 32'd0);
      RESET = 1'b1;
      repeat (6) step();
      TECLA_VALIDA = 1'b0;
      repeat (3) step();
      press(4'hA, 5);
      check_eq("midrst_commit", MONTO, 32'd3);

      check_eq("strobes_exclusive", 32'(n_both), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/keypad_capture.md
KEYPAD_CAPTURE -- requirements
Module: keypad_capture

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 3: consecutive stable cycles before a key is accepted (range 1..15).
REQ-002 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port RESET  input  1  synchronous, active-low reset.
REQ-004 SHALL have port TECLA_VALIDA  input  1  raw key-pressed level from keypad matrix.
REQ-005 SHALL have port TECLA  input  4  raw key code: 0-9 digit, 0xA ENTER, 0xB CLEAR, 0xC-0xF invalid.
REQ-006 SHALL have port MODO_MONTO  input  1  0 = PIN entry, 1 = amount entry; driven by controller.
REQ-007 SHALL have port DIGITO  output  4  last accepted PIN digit.
REQ-008 SHALL have port DIGITO_STB  output  1  one-cycle strobe, DIGITO valid.
REQ-009 SHALL have port MONTO  output  32  last committed amount, unsigned binary.
REQ-010 SHALL have port MONTO_STB  output  1  one-cycle strobe, MONTO valid.
REQ-011 SHALL have port DESBORDE  output  1  one-cycle pulse, digit rejected on overflow.

Function
REQ-012 SHALL implement key FSM: IDLE -> DEBOUNCE on TECLA_VALIDA=1; DEBOUNCE -> IDLE if TECLA_VALIDA drops or TECLA changes; DEBOUNCE -> HOLD after DEB_CYCLES stable cycles (key accepted); HOLD -> IDLE when TECLA_VALIDA=0.
REQ-013 SHALL accept exactly one event per press; holding a key SHALL NOT repeat.
REQ-014 SHALL assert output strobes on the cycle after acceptance (latency DEB_CYCLES+1 from stable press).
REQ-015 SHALL, in PIN mode, on accepted digit 0-9: DIGITO = code, DIGITO_STB = 1 for one cycle; ENTER/CLEAR ignored.
REQ-016 SHALL, in amount mode, on accepted digit d: acc = acc*10 + d, computed 36-bit wide; no DIGITO_STB.
REQ-017 SHALL, if acc*10+d > 0xFFFF_FFFF, leave acc unchanged and pulse DESBORDE for one cycle.
REQ-018 SHALL, in amount mode, on ENTER with at least one digit entered: MONTO = acc, MONTO_STB = 1 for one cycle, acc and digit count cleared.
REQ-019 SHALL ignore ENTER with zero digits entered (no MONTO_STB); acc=0 after digits "0" is a valid commit of 0.
REQ-020 SHALL, on CLEAR in amount mode, zero acc and digit count, no strobe.
REQ-021 SHALL ignore codes 0xC-0xF in both modes (FSM still passes through HOLD).
REQ-022 SHALL clear acc and digit count on any MODO_MONTO change; a key in DEBOUNCE/HOLD at the change is handled using the mode at acceptance.
REQ-023 SHALL hold DIGITO and MONTO between strobes; strobes never asserted simultaneously.

Reset
REQ-024 SHALL, while RESET=0 at a clock edge, set FSM=IDLE, debounce counter=0, acc=0, digit count=0, DIGITO=0, DIGITO_STB=0, MONTO=0, MONTO_STB=0, DESBORDE=0.
REQ-025 SHALL discard any press in progress on reset; a key still held after reset release SHALL be re-debounced from IDLE.

Configuration
REQ-026 SHALL support macro KEYPAD_DEBOUNCE_EN: defined -> DEBOUNCE state and counter per REQ-012; undefined -> key accepted on the first cycle TECLA_VALIDA=1 (IDLE -> HOLD directly), DEB_CYCLES ignored.

Structure
REQ-027 SHALL place key codes (ENTER=0xA, CLEAR=0xB), FSM state typedef and max-amount constant in shared package keypad_pkg.
REQ-028 SHALL implement the debounce FSM/counter as sub-module keypad_debounce (outputs accepted strobe + code); accumulator and strobes in the top.

Verification
REQ-029 SHALL cover: PIN mode, DEB_CYCLES=3, keys 3,4,7,3 each held 5 cycles -> four DIGITO_STB pulses with DIGITO 3,4,7,3, each 4 cycles after press start.
REQ-030 SHALL cover: amount mode, keys 2,0,0,0,ENTER -> single MONTO_STB with MONTO=2000 (0x7D0).
REQ-031 SHALL cover: press glitch of 2 cycles, then key 5 held 10 cycles -> exactly one accepted 5, no repeat.
REQ-032 SHALL cover: amount mode, keys 4,2,9,4,9,6,7,2,9,5 (4294967295) then 1 -> DESBORDE pulse; ENTER -> MONTO=0xFFFF_FFFF.
REQ-033 SHALL cover: amount digits 9,9, CLEAR, 1, ENTER -> MONTO=1; ENTER alone afterwards -> no MONTO_STB.
REQ-034 SHALL cover: RESET=0 for 1 cycle mid-entry (acc=12) while key held -> all outputs 0, key re-debounced after release of reset; ENTER then commits only digits entered after reset.
